// File: rtl/wb_pkg.sv
// ============================================================================
// Package     : wb_pkg
// Description : Shared widths and writeback entry types for the register-file
//               write-side front end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic    live;
    wb_req_t req;
  } wb_entry_t;

endpackage : wb_pkg

`default_nettype wire

// File: rtl/wb_fifo.sv
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer of writeback entries with push/pop/peek, a
//               parallel squash-by-rd port and a youngest-match lookup.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wb_req_t                 push_req,
  input  logic                    pop,
  output wb_entry_t               head,
  input  logic                    squash_en,
  input  logic [REG_AW-1:0]       squash_rd,
  input  logic [REG_AW-1:0]       lookup_rd,
  output logic                    lookup_hit,
  output logic [REG_DW-1:0]       lookup_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [PW-1:0] lookup_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head      = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Squash may touch unoccupied slots harmlessly; a push always rewrites live.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + (PW+1)'(w_do_push) - (PW+1)'(w_do_pop);
    if (squash_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem_q[i].req.rd == squash_rd) begin
          mem_d[i].live = 1'b0;
        end
      end
    end
    if (w_do_push) begin
      mem_d[wr_ptr_q].live = 1'b1;
      mem_d[wr_ptr_q].req  = push_req;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lookup_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_idx = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) && mem_q[lookup_idx].live &&
          (mem_q[lookup_idx].req.rd == lookup_rd)) begin
        lookup_hit  = 1'b1;
        lookup_data = mem_q[lookup_idx].req.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule : wb_fifo

`default_nettype wire

// File: rtl/reg_writeback_arbiter.sv
// ============================================================================
// Module      : reg_writeback_arbiter
// Description : Merges ALU writebacks and buffered load returns onto the single
//               register-file write port, with pending-write forwarding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = REG_AW,
  parameter int DW    = REG_DW
) (
  input  logic                    Clk,
  input  logic                    rst,
  input  logic                    alu_valid,
  input  logic [AW-1:0]           alu_rd,
  input  logic [DW-1:0]           alu_data,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [AW-1:0]           ld_rd,
  input  logic [DW-1:0]           ld_data,
  output logic                    WEN,
  output logic [AW-1:0]           RW,
  output logic [DW-1:0]           busW,
  input  logic [AW-1:0]           fwd_rx,
  output logic                    fwd_hit,
  output logic [DW-1:0]           fwd_data,
  output logic [$clog2(DEPTH):0]  pending_cnt
);

  wb_entry_t           fifo_head;
  wb_req_t             push_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_hit;
  logic [REG_DW-1:0]   fifo_hit_data;
  logic                w_alu_issue;
  logic                w_head_live;
  logic                w_push;
  logic                w_pop;

  logic                wen_q, wen_d;
  logic [AW-1:0]       rw_q, rw_d;
  logic [DW-1:0]       busw_q, busw_d;

  assign w_alu_issue = alu_valid && (alu_rd != '0);
  assign ld_ready    = !rst && !fifo_full;
  // rd==0 loads still complete the handshake; they are simply never queued.
  assign w_push      = ld_valid && ld_ready && (ld_rd != '0);
  assign w_head_live = !fifo_empty && fifo_head.live;
  assign w_pop       = !fifo_empty && (!fifo_head.live || !w_alu_issue);

  assign push_req.rd   = REG_AW'(ld_rd);
  assign push_req.data = REG_DW'(ld_data);

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (Clk),
    .rst         (rst),
    .push        (w_push),
    .push_req    (push_req),
    .pop         (w_pop),
    .head        (fifo_head),
    .squash_en   (w_alu_issue),
    .squash_rd   (REG_AW'(alu_rd)),
    .lookup_rd   (REG_AW'(fwd_rx)),
    .lookup_hit  (fifo_hit),
    .lookup_data (fifo_hit_data),
    .count       (pending_cnt),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_comb begin
    wen_d  = 1'b0;
    rw_d   = rw_q;
    busw_d = busw_q;
    if (w_alu_issue) begin
      wen_d  = 1'b1;
      rw_d   = alu_rd;
      busw_d = alu_data;
    end else if (w_head_live) begin
      wen_d  = 1'b1;
      rw_d   = AW'(fifo_head.req.rd);
      busw_d = DW'(fifo_head.req.data);
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      rw_q   <= '0;
      busw_q <= '0;
    end else begin
      wen_q  <= wen_d;
      rw_q   <= rw_d;
      busw_q <= busw_d;
    end
  end

  assign WEN  = wen_q;
  assign RW   = rw_q;
  assign busW = busw_q;

  // Queued entries are younger than the write already sitting in the output flops.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rx != '0) begin
      if (fifo_hit) begin
        fwd_hit  = 1'b1;
        fwd_data = DW'(fifo_hit_data);
      end else if (wen_q && (rw_q == fwd_rx)) begin
        fwd_hit  = 1'b1;
        fwd_data = busw_q;
      end
    end
  end

endmodule : reg_writeback_arbiter

`default_nettype wire

// File: tb/tb_reg_writeback_arbiter.sv
// ============================================================================
// Module      : tb_reg_writeback_arbiter
// Description : Directed self-checking bench for reg_writeback_arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_writeback_arbiter;

  logic        Clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        WEN;
  logic [4:0]  RW;
  logic [31:0] busW;
  logic [4:0]  fwd_rx;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  pending_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  reg_writeback_arbiter dut (
    .Clk         (Clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .WEN         (WEN),
    .RW          (RW),
    .busW        (busW),
    .fwd_rx      (fwd_rx),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .pending_cnt (pending_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic check_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    check_eq({tag, "_wen"}, 64'(WEN), 64'(1));
    check_eq({tag, "_rw"}, 64'(RW), 64'(rd));
    check_eq({tag, "_busw"}, 64'(busW), 64'(data));
  endtask

  initial begin
    rst       = 1'b1;
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b1;
    ld_rd     = 5'd1;
    ld_data   = 32'hDEAD;
    fwd_rx    = '0;

    // Reset held for three edges with a load pending
    tick();
    sample();
    check_eq("rst_ready0", 64'(ld_ready), 64'(0));
    check_eq("rst_wen0", 64'(WEN), 64'(0));
    check_eq("rst_cnt0", 64'(pending_cnt), 64'(0));
    tick();
    sample();
    check_eq("rst_ready1", 64'(ld_ready), 64'(0));
    check_eq("rst_cnt1", 64'(pending_cnt), 64'(0));
    tick();
    rst      = 1'b0;
    ld_valid = 1'b0;
    sample();
    check_eq("post_rst_ready", 64'(ld_ready), 64'(1));
    check_eq("post_rst_wen", 64'(WEN), 64'(0));
    check_eq("post_rst_cnt", 64'(pending_cnt), 64'(0));
    check_eq("post_rst_rw", 64'(RW), 64'(0));
    check_eq("post_rst_busw", 64'(busW), 64'(0));

    // ALU only
    tick();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    sample();
    tick();
    alu_valid = 1'b0; fwd_rx = 5'd5;
    sample();
    check_wr("alu", 5'd5, 32'h1234);
    check_eq("alu_fwd_hit", 64'(fwd_hit), 64'(1));
    check_eq("alu_fwd_data", 64'(fwd_data), 64'h1234);
    tick();
    fwd_rx = 5'd0;
    sample();
    check_eq("alu_idle_wen", 64'(WEN), 64'(0));
    check_eq("fwd_rx0_hit", 64'(fwd_hit), 64'(0));
    check_eq("fwd_rx0_data", 64'(fwd_data), 64'(0));

    // Load backpressure: ALU busy on rd=9, loads rd=1..5
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int k = 1; k <= 4; k++) begin
      tick();
      ld_valid = 1'b1; ld_rd = 5'(k); ld_data = 32'h100 + 32'(k);
      sample();
      check_eq("bp_ready_open", 64'(ld_ready), 64'(1));
    end
    tick();
    ld_rd = 5'd5; ld_data = 32'h105;
    sample();
    check_eq("bp_full_ready", 64'(ld_ready), 64'(0));
    check_eq("bp_full_cnt", 64'(pending_cnt), 64'(4));
    check_wr("bp_alu", 5'd9, 32'h99);
    tick();
    alu_valid = 1'b0;
    sample();
    check_eq("bp_hold_cnt", 64'(pending_cnt), 64'(4));
    check_eq("bp_hold_ready", 64'(ld_ready), 64'(0));
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) ld_valid = 1'b0;
      sample();
      check_wr("bp_drain", 5'(k), 32'h100 + 32'(k));
    end
    tick();
    sample();
    check_eq("bp_done_wen", 64'(WEN), 64'(0));
    check_eq("bp_done_cnt", 64'(pending_cnt), 64'(0));

    // Squash: queued load rd=7 overwritten by a later ALU rd=7
    tick();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hAA;
    sample();
    tick();
    alu_rd = 5'd7; alu_data = 32'hBB; ld_valid = 1'b0;
    sample();
    check_eq("sq_cnt1", 64'(pending_cnt), 64'(1));
    tick();
    alu_valid = 1'b0; fwd_rx = 5'd7;
    sample();
    check_wr("sq_alu", 5'd7, 32'hBB);
    check_eq("sq_fwd_hit", 64'(fwd_hit), 64'(1));
    check_eq("sq_fwd_data", 64'(fwd_data), 64'hBB);
    tick();
    fwd_rx = 5'd0;
    sample();
    check_eq("sq_dead_wen", 64'(WEN), 64'(0));
    check_eq("sq_dead_cnt", 64'(pending_cnt), 64'(0));

    // Same-cycle tie: load is younger than the ALU write
    tick();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h22;
    sample();
    tick();
    alu_valid = 1'b0; ld_valid = 1'b0; fwd_rx = 5'd3;
    sample();
    check_wr("tie_alu", 5'd3, 32'h11);
    check_eq("tie_fwd_hit", 64'(fwd_hit), 64'(1));
    check_eq("tie_fwd_data", 64'(fwd_data), 64'h22);
    tick();
    fwd_rx = 5'd0;
    sample();
    check_wr("tie_ld", 5'd3, 32'h22);
    check_eq("tie_cnt", 64'(pending_cnt), 64'(0));

    // rd==0 on both sources
    tick();
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    sample();
    check_eq("rd0_ld_ready", 64'(ld_ready), 64'(1));
    tick();
    ld_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
    sample();
    check_eq("rd0_ld_cnt", 64'(pending_cnt), 64'(0));
    check_eq("rd0_ld_wen", 64'(WEN), 64'(0));
    tick();
    alu_valid = 1'b0;
    sample();
    check_eq("rd0_alu_wen", 64'(WEN), 64'(0));

    // Mid-run reset with three entries queued behind a busy ALU
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    for (int k = 0; k < 3; k++) begin
      tick();
      ld_valid = 1'b1;
      ld_rd    = (k == 2) ? 5'd12 : 5'd10;
      ld_data  = 32'hC0 + 32'(k);
    end
    tick();
    ld_valid = 1'b0; rst = 1'b1; fwd_rx = 5'd10;
    sample();
    check_eq("mr_cnt3", 64'(pending_cnt), 64'(3));
    check_eq("mr_ready_rst", 64'(ld_ready), 64'(0));
    check_eq("mr_fwd_young_hit", 64'(fwd_hit), 64'(1));
    check_eq("mr_fwd_young_data", 64'(fwd_data), 64'hC1);
    tick();
    rst = 1'b0; alu_valid = 1'b0; fwd_rx = 5'd0;
    sample();
    check_eq("mr_cnt0", 64'(pending_cnt), 64'(0));
    check_eq("mr_wen0", 64'(WEN), 64'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      sample();
      check_eq("mr_no_wen", 64'(WEN), 64'(0));
      check_eq("mr_no_cnt", 64'(pending_cnt), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_writeback_arbiter

`default_nettype wire
